task1: RTL and testbench

- UART loopback-and-display block for a 50 MHz board.
- Receives 8N1 serial bytes at 9600 baud on uart_rxd and shows the last good byte as two hex digits on a 6-digit multiplexed 7-segment display.
- Echoes each good byte back on uart_txd.
- Top-level leaf: the ports go directly to board pins.

---
 rtl/task1.sv | 244 ++++++++++++++++++++++++
 tb/tb_task1.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/task1.sv
// UART loopback with hex display: receives 8N1 bytes, echoes each good byte
// back on uart_txd and shows the last good byte on a 6-digit 7-seg display.
module task1 #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int BIT_CNT  = CLK_FREQ / BAUD,
  parameter int SCAN_CNT = 50_000
) (
  input  logic       clk,
  input  logic       res,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic [7:0] seg_led,
  output logic [5:0] seg_sel
);

  localparam int CW = $clog2(BIT_CNT);
  localparam int SW = $clog2(SCAN_CNT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CNT / 2 - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CNT - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_t;

  // Active-low glyph for one hex nibble; dp (bit 7) is always off.
  function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
    // NOTE: the default arm guarantees a value for every input, so no latch
    // can be inferred wherever this function is used combinationally.
    case (nib)
      4'h0: hex_glyph = 8'hC0;
      4'h1: hex_glyph = 8'hF9;
      4'h2: hex_glyph = 8'hA4;
      4'h3: hex_glyph = 8'hB0;
      4'h4: hex_glyph = 8'h99;
      4'h5: hex_glyph = 8'h92;
      4'h6: hex_glyph = 8'h82;
      4'h7: hex_glyph = 8'hF8;
      4'h8: hex_glyph = 8'h80;
      4'h9: hex_glyph = 8'h90;
      4'hA: hex_glyph = 8'h88;
      4'hB: hex_glyph = 8'h83;
      4'hC: hex_glyph = 8'hC6;
      4'hD: hex_glyph = 8'hA1;
      4'hE: hex_glyph = 8'h86;
      4'hF: hex_glyph = 8'h8E;
      default: hex_glyph = 8'hFF;
    endcase
  endfunction

  // ---------------------------------------------------------------- RX path
  logic rx_meta, rx_sync, rx_prev;
  logic rx_fall;

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge clk or negedge res) begin
    // NOTE: these flops reset to 1 (line idle) so releasing reset cannot
    // look like a start-bit edge; non-blocking assignments keep the chain
    // a true shift of one stage per clock.
    if (!res) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic [7:0]    rx_data;
  logic          rx_done;

  // Receive FSM: validate start at half-bit, then sample each bit mid-point.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_done  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_fall) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_idx == 3'd7) rx_state <= RX_STOP;
            else                rx_idx   <= rx_idx + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            if (rx_sync) begin
              rx_done  <= 1'b1;
              rx_data  <= rx_shift;
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_WAIT_HIGH;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_sync) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------- holding / display
  logic [7:0] hold_data;
  logic       hold_full;
  logic [7:0] disp_byte;
  logic       tx_start;

  // Newest good byte wins: a load in the same cycle as a TX start keeps the
  // register full with the new byte while TX takes the old one.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      hold_data <= '0;
      hold_full <= 1'b0;
      disp_byte <= '0;
    end else if (rx_done) begin
      hold_data <= rx_data;
      hold_full <= 1'b1;
      disp_byte <= rx_data;
    end else if (tx_start) begin
      hold_full <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- TX path
  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_idx;
  logic [9:0]    tx_frame;
  logic          tx_last;

  // Starting straight out of the stop bit keeps frames exactly 10 bits long,
  // so TX never falls behind RX running at the same baud.
  assign tx_last  = (tx_state == TX_SEND) && (tx_cnt == BIT_LAST) && (tx_idx == 4'd9);
  assign tx_start = hold_full && ((tx_state == TX_IDLE) || tx_last);

  // Transmit FSM: shifts out start, 8 data bits LSB first, stop.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_frame <= '1;
      uart_txd <= 1'b1;
    end else if (tx_start) begin
      tx_state <= TX_SEND;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_frame <= {1'b1, hold_data, 1'b0};
      uart_txd <= 1'b0;
    end else if (tx_state == TX_SEND) begin
      if (tx_cnt == BIT_LAST) begin
        tx_cnt <= '0;
        if (tx_idx == 4'd9) begin
          tx_state <= TX_IDLE;
          uart_txd <= 1'b1;
        end else begin
          tx_idx   <= tx_idx + 1'b1;
          tx_frame <= {1'b1, tx_frame[9:1]};
          uart_txd <= tx_frame[1];
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- display
  logic [SW-1:0] scan_cnt;
  logic [2:0]    digit;

  // Scan timer: moves to the next digit every SCAN_CNT cycles, 0..5.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      scan_cnt <= '0;
      digit    <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      digit    <= (digit == 3'd5) ? 3'd0 : digit + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Registered segment and select drive, updated together.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      seg_sel <= 6'b111111;
      seg_led <= 8'hFF;
    end else begin
      seg_sel <= ~(6'b000001 << digit);
      case (digit)
        3'd0:    seg_led <= hex_glyph(disp_byte[3:0]);
        3'd1:    seg_led <= hex_glyph(disp_byte[7:4]);
        default: seg_led <= 8'hFF;
      endcase
    end
  end

endmodule

// File: tb/tb_task1.sv
// Bench for task1: random and directed UART frames, echo decoded by an
// independent line monitor against a queue of expected bytes, display
// checked against the last-good-byte model.
module tb_task1;

  localparam int CLK_FREQ = 320;
  localparam int BAUD     = 20;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam int SCAN     = 40;
  localparam int FRAME    = 10 * BIT;

  localparam logic [7:0] GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       uart_txd;
  logic [7:0] seg_led;
  logic [5:0] seg_sel;

  task1 #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .SCAN_CNT(SCAN)
  ) dut (
    .clk     (clk),
    .res     (res),
    .uart_rxd(uart_rxd),
    .uart_txd(uart_txd),
    .seg_led (seg_led),
    .seg_sel (seg_sel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] data;
    int         deadline;  // 0 = no latency check
  } echo_t;

  echo_t      exp_q[$];
  logic [7:0] disp_model = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one serial frame; a good frame updates the reference model.
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit timed);
    echo_t e;
    uart_rxd = 1'b0;
    cycles(BIT);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      cycles(BIT);
    end
    uart_rxd = stop;
    if (stop) begin
      e.data     = d;
      e.deadline = timed ? cyc + BIT / 2 + 7 : 0;
      exp_q.push_back(e);
      disp_model = d;
    end
    cycles(BIT);
    if (!stop) begin
      cycles(BIT);
      uart_rxd = 1'b1;
      cycles(BIT);
    end
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 4 * FRAME) begin
      cycles(1);
      t++;
    end
    check({tag, "_echo_drained"}, exp_q.size(), 0);
  endtask

  // Watch a full scan rotation and compare each digit with the model.
  task automatic check_display(input string tag);
    logic [5:0] prev_sel;
    logic [7:0] led_seen [6];
    logic [7:0] exp_led;
    int bad_onehot = 0, bad_period = 0, bad_order = 0;
    int last_change = -1;
    int d, prev_d;
    for (int i = 0; i < 6; i++) led_seen[i] = 8'h00;
    prev_sel = seg_sel;
    prev_d   = -1;
    for (int i = 0; i < 6; i++) if (!prev_sel[i]) prev_d = i;
    for (int t = 0; t < 7 * SCAN; t++) begin
      cycles(1);
      if ($countones(~seg_sel) != 1) bad_onehot++;
      d = -1;
      for (int i = 0; i < 6; i++) if (!seg_sel[i]) d = i;
      if (d >= 0) led_seen[d] = seg_led;
      if (seg_sel != prev_sel) begin
        if (last_change >= 0 && cyc - last_change != SCAN) bad_period++;
        if (prev_d >= 0 && d != (prev_d + 1) % 6) bad_order++;
        last_change = cyc;
        prev_sel    = seg_sel;
        prev_d      = d;
      end
    end
    check({tag, "_sel_onehot"}, bad_onehot, 0);
    check({tag, "_scan_period"}, bad_period, 0);
    check({tag, "_scan_order"}, bad_order, 0);
    for (int i = 0; i < 6; i++) begin
      exp_led = (i == 0) ? GLYPH[disp_model[3:0]] :
                (i == 1) ? GLYPH[disp_model[7:4]] : 8'hFF;
      check($sformatf("%s_digit%0d", tag, i), led_seen[i], exp_led);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_txd"}, uart_txd, 1'b1);
    check({tag, "_seg_sel"}, seg_sel, 6'b111111);
    check({tag, "_seg_led"}, seg_led, 8'hFF);
  endtask

  // Echo monitor: samples every cycle of a frame from the falling edge,
  // decodes bit mid-points and flags any level change inside a bit.
  logic samp [FRAME];
  initial begin
    logic [9:0] fr;
    int         start_cyc, viol;
    echo_t      e;
    forever begin
      @(negedge uart_txd);
      #1;
      start_cyc = cyc;
      for (int k = 0; k < FRAME; k++) begin
        if (k > 0) begin
          @(posedge clk);
          #1;
        end
        samp[k] = uart_txd;
      end
      viol = 0;
      for (int b = 0; b < 10; b++) begin
        fr[b] = samp[b * BIT + BIT / 2];
        for (int p = 1; p < BIT - 1; p++)
          if (samp[b * BIT + p] !== fr[b]) viol++;
      end
      check("echo_start_bit", fr[0], 1'b0);
      check("echo_stop_bit", fr[9], 1'b1);
      check("echo_bit_width", viol, 0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_echo: got %02h, expected no frame", fr[8:1]);
      end else begin
        e = exp_q.pop_front();
        check("echo_data", fr[8:1], e.data);
        if (e.deadline != 0) check("echo_latency", start_cyc <= e.deadline, 1'b1);
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic       stop;

    // Reset: asynchronous values visible before any clock edge.
    #1 res = 1'b0;
    #1 check_reset_outputs("reset");
    cycles(100);
    res = 1'b1;
    cycles(3);
    check_display("idle");
    check("idle_txd", uart_txd, 1'b1);

    // First byte, then the same byte again after a long idle gap.
    send_frame(8'hA5, 1'b1, 1'b1);
    drain("a5_first");
    check_display("a5_first");
    cycles(20 * BIT);
    send_frame(8'hA5, 1'b1, 1'b1);
    drain("a5_second");
    check_display("a5_second");

    // Short glitch must be rejected as a false start.
    uart_rxd = 1'b0;
    cycles(BIT / 4);
    uart_rxd = 1'b1;
    cycles(2 * BIT);
    check_display("glitch");
    send_frame(8'h3C, 1'b1, 1'b1);
    drain("after_glitch");
    check_display("after_glitch");

    // Framing error is discarded; the following good frame is accepted.
    send_frame(8'h5A, 1'b0, 1'b0);
    cycles(2 * FRAME);
    check_display("framing_err");
    send_frame(8'h5A, 1'b1, 1'b1);
    drain("after_framing");
    check_display("after_framing");

    // Back-to-back frames at full rate.
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    drain("back_to_back");
    check_display("back_to_back");

    // Random traffic with occasional framing errors and random gaps.
    for (int n = 0; n < 14; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(d, stop, 1'b0);
      cycles($urandom_range(0, 2) * BIT);
    end
    drain("random");
    check_display("random");

    // Reset in the middle of data bit 4: partial byte must vanish.
    cycles(2 * BIT);
    d = 8'h96;
    uart_rxd = 1'b0;
    cycles(BIT);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = d[i];
      cycles(BIT);
    end
    uart_rxd = d[4];
    cycles(BIT / 2);
    res = 1'b0;
    #1 check_reset_outputs("mid_frame_reset");
    disp_model = 8'h00;
    uart_rxd   = 1'b1;
    cycles(10);
    res = 1'b1;
    cycles(2 * FRAME);
    check("post_reset_no_echo_pending", exp_q.size(), 0);
    check("post_reset_txd", uart_txd, 1'b1);
    check_display("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
